fifo_wr_sched: RTL and testbench
================================

# fifo_wr_sched

Write-side scheduler for one shared 512x128 FIFO in the PCIe/AXI datapath. Sequences the FIFO's reset and recovery window, then shares its single write port among N packet-streaming sources using round-robin arbitration at packet granularity. Each packet is written contiguously, and backpressure comes from the FIFO's prog_full flag. Sits between the stream producers and the FIFO's din/dinp/wr_en/rst pins.

## Interface
- N_SRC, 4: number of requesters, 2..8.
- RST_HOLD, 8: cycles fifo_rst is held high per reset sequence, ≥5.
- RST_WAIT, 8: cycles after fifo_rst falls before any write is allowed.
- clk  in  1  sole clock; FIFO read and write clocks are tied to the same net.
- rst_n  in  1  asynchronous, active-low reset.
- src_valid  in  N_SRC  per-source beat valid.
- src_data  in  128*N_SRC  beat data; source i occupies [128*i+127:128*i].
- src_datap  in  16*N_SRC  parity or sideband, packed the same way.
- src_last  in  N_SRC  final beat of a packet.
- src_ready  out  N_SRC  per-source accept; at most one bit set.
- flush  in  1  request a FIFO re-initialisation; single-cycle pulse.
- fifo_rst  out  1  active-high reset to the FIFO.
- fifo_din  out  128  muxed data.
- fifo_dinp  out  16  muxed parity.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag, already registered inside the FIFO.
- fifo_prog_full  in  1  FIFO almost-full flag.
- init_done  out  1  high while the FIFO is usable, i.e. in IDLE or BURST.
- grant_id  out  clog2(N_SRC)  index of the current or most recent grantee.
- overflow_err  out  1  sticky; cleared only by rst_n.

## Operation
- States: HOLD, WAIT, IDLE, BURST. Reset state is HOLD.
- HOLD:
  - fifo_rst=1; a counter runs RST_HOLD cycles.
  - Then go to WAIT.
- WAIT:
  - fifo_rst=0; a counter runs RST_WAIT cycles.
  - Then go to IDLE and set init_done=1.
- IDLE:
  - If flush_pend: go to HOLD and clear flush_pend.
  - Else if fifo_prog_full=0 and any src_valid: pick a winner round-robin.
    - The search starts at (last_grant+1) mod N_SRC.
    - Load grant_id=winner and last_grant=winner, then go to BURST.
- BURST:
  - src_ready[grant_id] = ~fifo_prog_full; all other ready bits are 0.
  - fifo_wr_en = src_valid[grant_id] & src_ready[grant_id].
  - fifo_din/fifo_dinp = the grantee's slice. The mux is combinational from registered grant_id.
  - An accepted beat with src_last=1 moves the FSM to IDLE.
  - The grant is never revoked mid-packet. prog_full only stalls the grant.
- flush:
  - Sets flush_pend in any state.
  - It takes effect only from IDLE, so a packet in flight always completes.
  - Flush in HOLD or WAIT: the sequence does not restart; the pend is consumed on the next IDLE, which triggers one more sequence.
- overflow_err: sets when fifo_wr_en & fifo_full in the same cycle. This is never expected; ALMOST_FULL_OFFSET provides the margin.
- init_done is 0 in HOLD and WAIT. src_ready and fifo_wr_en are always 0 outside BURST.
- Counters are sized for max(RST_HOLD,RST_WAIT). No wrap occurs; each counter reloads on state entry.

## Timing
- Reset values, asynchronous on rst_n low:
  - state=HOLD, fifo_rst=1, src_ready=0, fifo_wr_en=0.
  - init_done=0, grant_id=0, last_grant=N_SRC-1 (so source 0 wins first), overflow_err=0, flush_pend=0.
- After rst_n rises:
  - fifo_rst stays high for RST_HOLD rising edges.
  - init_done rises RST_HOLD+RST_WAIT cycles later.
- Arbitration latency: valid in IDLE at cycle t gives src_ready high at t+1, if prog_full is low at t+1.
- Back-to-back packets: one idle bubble after each last beat. Peak throughput is L/(L+1) for L-beat packets.
- prog_full rising at cycle t: src_ready drops in cycle t (combinational). A resumed beat is written the cycle prog_full falls.
- Simultaneous flush with a last beat accepted in BURST: goes to IDLE, then HOLD on the next cycle.
- rst_n asserted mid-packet: the beat in flight is lost and fifo_rst asserts immediately. Sources must restart their packets.

## Test plan
- Reset sequencing (RST_HOLD=8, RST_WAIT=8): release rst_n -> fifo_rst high for exactly 8 cycles, init_done high at cycle 16, no wr_en before it.
- Round-robin: all 4 sources continuously valid with 3-beat packets -> grants 0,1,2,3,0,…; each packet contiguous; one bubble between packets; 12 writes in 16 cycles.
- Backpressure: drive prog_full high at beat 2 of a 5-beat packet for 6 cycles -> exactly 2 beats written, ready low for 6 cycles, remaining 3 beats follow in order, grant unchanged.
- Flush mid-packet: pulse flush at beat 1 of a 4-beat packet -> all 4 beats written, then fifo_rst high 8 cycles, init_done low 16 cycles, then arbitration resumes from last_grant+1.
- Overflow check: force fifo_full=1 while a beat is accepted -> overflow_err sets and stays 1 until rst_n.
- Async reset mid-burst: drop rst_n at beat 2 -> same cycle src_ready=0, fifo_wr_en=0, fifo_rst=1, grant_id=0.

Source files
------------

// File: rtl/fifo_wr_sched.sv
// rtl/fifo_wr_sched.sv - FIFO reset sequencing and round-robin packet write scheduler
module fifo_wr_sched #(
    parameter int N_SRC    = 4,
    parameter int RST_HOLD = 8,
    parameter int RST_WAIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_SRC-1:0]           src_valid,
    input  logic [128*N_SRC-1:0]       src_data,
    input  logic [16*N_SRC-1:0]        src_datap,
    input  logic [N_SRC-1:0]           src_last,
    output logic [N_SRC-1:0]           src_ready,
    input  logic                       flush,
    output logic                       fifo_rst,
    output logic [127:0]               fifo_din,
    output logic [15:0]                fifo_dinp,
    output logic                       fifo_wr_en,
    input  logic                       fifo_full,
    input  logic                       fifo_prog_full,
    output logic                       init_done,
    output logic [$clog2(N_SRC)-1:0]   grant_id,
    output logic                       overflow_err
);

    localparam int GW   = $clog2(N_SRC);
    localparam int CMAX = (RST_HOLD > RST_WAIT) ? RST_HOLD : RST_WAIT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] HOLD_END = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] WAIT_END = CW'(RST_WAIT - 1);

    typedef enum logic [1:0] {HOLD, WAIT, IDLE, BURST} state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] winner;
    logic          win_found;
    logic          grant_load;
    logic          flush_pend;
    logic          flush_take;
    logic          cur_valid;
    logic          cur_last;

    // Round-robin search: the candidate closest after last_grant wins, so
    // iterate from the farthest distance down and let the nearest overwrite.
    always_comb begin
        winner    = last_grant;
        win_found = 1'b0;
        for (int k = N_SRC; k >= 1; k--) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (src_valid[i] && (((int'(last_grant) + k) % N_SRC) == i)) begin
                    winner    = GW'(i);
                    win_found = 1'b1;
                end
            end
        end
    end

    // Grantee mux, driven from the registered grant so the data path stays short.
    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        fifo_din  = '0;
        fifo_dinp = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_id == GW'(i)) begin
                cur_valid = src_valid[i];
                cur_last  = src_last[i];
                fifo_din  = src_data[128*i +: 128];
                fifo_dinp = src_datap[16*i +: 16];
            end
        end
    end

    // Next-state and output decode; ready/write only ever asserted in BURST.
    always_comb begin
        state_nx   = state;
        fifo_rst   = 1'b0;
        init_done  = 1'b0;
        src_ready  = '0;
        fifo_wr_en = 1'b0;
        grant_load = 1'b0;
        flush_take = 1'b0;
        case (state)
            HOLD: begin
                fifo_rst = 1'b1;
                if (cnt == HOLD_END) state_nx = WAIT;
            end
            WAIT: begin
                if (cnt == WAIT_END) state_nx = IDLE;
            end
            IDLE: begin
                init_done = 1'b1;
                if (flush_pend) begin
                    flush_take = 1'b1;
                    state_nx   = HOLD;
                end else if (!fifo_prog_full && win_found) begin
                    grant_load = 1'b1;
                    state_nx   = BURST;
                end
            end
            BURST: begin
                init_done = 1'b1;
                for (int i = 0; i < N_SRC; i++) begin
                    src_ready[i] = (grant_id == GW'(i)) && !fifo_prog_full;
                end
                fifo_wr_en = cur_valid && !fifo_prog_full;
                if (fifo_wr_en && cur_last) state_nx = IDLE;
            end
            default: state_nx = HOLD;
        endcase
    end

    // State register and sequencing counter; the counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else if (state == HOLD || state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Grant registers; last_grant resets to the top index so source 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id   <= '0;
            last_grant <= GW'(N_SRC - 1);
        end else if (grant_load) begin
            grant_id   <= winner;
            last_grant <= winner;
        end
    end

    // Pending flush (consumed only from IDLE) and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            flush_pend <= (flush_pend && !flush_take) || flush;
            if (fifo_wr_en && fifo_full) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// tb/tb_fifo_wr_sched.sv - directed and randomized checks of fifo_wr_sched against a behavioural model
module tb_fifo_wr_sched;
    localparam int N     = 4;
    localparam int HOLD  = 8;
    localparam int WAITC = 8;
    localparam int GW    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     src_valid = '0;
    logic [N-1:0]     src_last = '0;
    logic [N-1:0]     src_ready;
    logic [128*N-1:0] src_data = '0;
    logic [16*N-1:0]  src_datap = '0;
    logic             flush = 1'b0;
    logic             fifo_rst;
    logic [127:0]     fifo_din;
    logic [15:0]      fifo_dinp;
    logic             fifo_wr_en;
    logic             fifo_full = 1'b0;
    logic             fifo_prog_full = 1'b0;
    logic             init_done;
    logic [GW-1:0]    grant_id;
    logic             overflow_err;

    int checks = 0;
    int failures = 0;

    fifo_wr_sched #(.N_SRC(N), .RST_HOLD(HOLD), .RST_WAIT(WAITC)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_data(src_data), .src_datap(src_datap),
        .src_last(src_last), .src_ready(src_ready), .flush(flush),
        .fifo_rst(fifo_rst), .fifo_din(fifo_din), .fifo_dinp(fifo_dinp),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .fifo_prog_full(fifo_prog_full),
        .init_done(init_done), .grant_id(grant_id), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    // source stimulus state
    int sb[N];
    int plen[N];
    int pc[N];
    logic [N-1:0] vmask = '0;
    bit rmode = 0;
    int fixlen = 3;

    // reference model: countdown of the init window, packet owner, round-robin pointer
    int m_timer, m_owner, m_last, m_gid;
    bit m_pend, m_ovf, e_wr;

    // observation statistics for directed phases
    int n_wr, n_rdy, n_rst, n_nodone;
    int q_src[$];
    int q_beat[$];
    int errs;

    function automatic int newlen();
        return (fixlen > 0) ? fixlen : int'($urandom_range(1, 5));
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int l);
        fixlen = l;
        for (int i = 0; i < N; i++) if (sb[i] == 0) plen[i] = l;
    endtask

    task automatic clr();
        n_wr = 0; n_rdy = 0; n_rst = 0; n_nodone = 0;
        q_src.delete(); q_beat.delete();
    endtask

    task automatic mreset();
        m_timer = HOLD + WAITC; m_owner = -1; m_last = N - 1; m_gid = 0;
        m_pend = 0; m_ovf = 0;
        for (int i = 0; i < N; i++) begin sb[i] = 0; plen[i] = newlen(); end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            src_valid[i] = rmode ? ($urandom_range(0, 3) != 0) : vmask[i];
            src_last[i]  = (sb[i] == plen[i] - 1);
            src_data[128*i +: 128] = {32'(i), 32'(pc[i]), 32'(sb[i]), 32'hC0DE0000 | 32'(i)};
            src_datap[16*i +: 16]  = 16'(i * 256 + sb[i]);
        end
    endtask

    task automatic compare();
        logic [N-1:0] er;
        e_wr = (m_owner >= 0) && src_valid[m_owner] && !fifo_prog_full;
        er = (m_owner >= 0 && !fifo_prog_full) ? (N'(1) << m_owner) : '0;
        chk("fifo_rst", fifo_rst, m_timer > WAITC);
        chk("init_done", init_done, m_timer == 0);
        chk("src_ready", src_ready, er);
        chk("fifo_wr_en", fifo_wr_en, e_wr);
        chk("grant_id", grant_id, m_gid);
        chk("overflow_err", overflow_err, m_ovf);
        if (m_owner >= 0) begin
            chk("fifo_din", fifo_din, src_data[128*m_owner +: 128]);
            chk("fifo_dinp", fifo_dinp, src_datap[16*m_owner +: 16]);
        end
        if (fifo_wr_en) begin
            n_wr++;
            q_src.push_back(int'(fifo_din[127:96]));
            q_beat.push_back(int'(fifo_din[63:32]));
        end
        if (|src_ready) n_rdy++;
        if (fifo_rst) n_rst++;
        if (!init_done) n_nodone++;
    endtask

    task automatic update();
        bit take, done, found;
        take = 0; done = 0; found = 0;
        if (e_wr && fifo_full) m_ovf = 1;
        if (e_wr) begin
            if (sb[m_owner] == plen[m_owner] - 1) begin
                sb[m_owner] = 0; pc[m_owner]++; plen[m_owner] = newlen(); done = 1;
            end else begin
                sb[m_owner]++;
            end
        end
        if (m_timer > 0) begin
            m_timer--;
        end else if (m_owner >= 0) begin
            if (done) m_owner = -1;
        end else if (m_pend) begin
            m_timer = HOLD + WAITC; take = 1;
        end else if (!fifo_prog_full) begin
            for (int k = 1; k <= N; k++) begin
                if (!found && src_valid[(m_last + k) % N]) begin
                    found = 1; m_owner = (m_last + k) % N;
                end
            end
            if (found) begin m_last = m_owner; m_gid = m_owner; end
        end
        m_pend = (m_pend && !take) || flush;
    endtask

    task automatic step();
        apply();
        #1;
        compare();
        @(posedge clk);
        if (rst_n) update();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < N; i++) pc[i] = 0;
        mreset();
        @(negedge clk);
        step(); step();

        // reset sequencing
        rst_n = 1'b1;
        clr();
        repeat (20) step();
        chk("rst_cycles", n_rst, 8);
        chk("init_latency", n_nodone, 16);
        chk("early_writes", n_wr, 0);

        // round robin, 3-beat packets, all sources valid
        set_len(3);
        vmask = '1;
        clr();
        repeat (16) step();
        vmask = '0;
        chk("rr_writes", n_wr, 12);
        errs = 0;
        foreach (q_src[j]) if (q_src[j] != j / 3 || q_beat[j] != j % 3) errs++;
        chk("rr_order", errs, 0);
        repeat (3) step();

        // backpressure: stall 6 cycles after 2 beats of a 5-beat packet
        set_len(5);
        vmask = 4'b0100;
        clr();
        for (int c = 0; c < 20 && n_wr < 2; c++) step();
        chk("bp_pre_writes", n_wr, 2);
        fifo_prog_full = 1'b1;
        clr();
        repeat (6) step();
        chk("bp_stall_writes", n_wr, 0);
        chk("bp_stall_ready", n_rdy, 0);
        fifo_prog_full = 1'b0;
        clr();
        for (int c = 0; c < 20 && n_wr < 3; c++) step();
        vmask = '0;
        chk("bp_post_writes", n_wr, 3);
        errs = 0;
        foreach (q_src[j]) if (q_src[j] != 2 || q_beat[j] != j + 2) errs++;
        chk("bp_order", errs, 0);
        chk("bp_grant", grant_id, 2);
        step();

        // flush mid-packet on source 3 (next after last grant 2)
        set_len(4);
        vmask = 4'b1000;
        clr();
        for (int c = 0; c < 20 && n_wr < 1; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 0; c < 20 && n_wr < 4; c++) step();
        vmask = '0;
        chk("flush_pkt_writes", n_wr, 4);
        clr();
        repeat (20) step();
        chk("flush_rst_cycles", n_rst, 8);
        chk("flush_init_low", n_nodone, 16);
        set_len(2);
        vmask = '1;
        clr();
        for (int c = 0; c < 20 && n_wr < 1; c++) step();
        vmask = '0;
        chk("flush_resume_src", (q_src.size() > 0) ? q_src[0] : -1, 0);
        for (int c = 0; c < 20 && n_wr < 2; c++) step();
        step();

        // randomized traffic with backpressure and occasional flushes
        fixlen = 0;
        rmode = 1;
        for (int c = 0; c < 400; c++) begin
            fifo_prog_full = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 49) == 0);
            step();
        end
        rmode = 0; flush = 1'b0; fifo_prog_full = 1'b0;

        // overflow: a write while full sets the sticky flag
        vmask = '1;
        fifo_full = 1'b1;
        clr();
        for (int c = 0; c < 60 && n_wr < 1; c++) step();
        fifo_full = 1'b0;
        chk("ovf_write_seen", n_wr, 1);
        repeat (10) step();
        chk("ovf_sticky", overflow_err, 1);
        vmask = '0;

        // reset clears overflow, then async reset mid-burst
        rst_n = 1'b0;
        mreset();
        step();
        rst_n = 1'b1;
        repeat (20) step();
        set_len(5);
        vmask = 4'b0010;
        clr();
        for (int c = 0; c < 20 && n_wr < 2; c++) step();
        chk("ar_pre_grant", grant_id, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_ready", src_ready, 0);
        chk("ar_wr_en", fifo_wr_en, 0);
        chk("ar_fifo_rst", fifo_rst, 1);
        chk("ar_grant", grant_id, 0);
        chk("ar_overflow", overflow_err, 0);
        mreset();
        vmask = '0;
        step();
        rst_n = 1'b1;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
